fifo_wr_packer: RTL and testbench



---
 rtl/fifo_wr_packer.sv | 114 +++++++++++
 tb/tb_fifo_wr_packer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_packer.sv
// Write-side packer: narrow valid/ready chunks are packed LSB-first into
// FIFO-width words and pushed under registered full back-pressure.
//
// state | meaning
// EMPTY | no chunks held, no word pending
// FILL  | partial word accumulating, no word pending
// HOLD  | completed word waiting in out_reg; accumulation may continue
module fifo_wr_packer #(
  parameter int              IN_W  = 2,
  parameter int              OUT_W = 8,
  parameter logic [IN_W-1:0] PAD   = '0,
  parameter int              CNT_W = 16
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             din_last,
  output logic             din_ready,
  input  logic             fifo_wfull,
  output logic             fifo_winc,
  output logic [OUT_W-1:0] fifo_wdata,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             busy
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [OUT_W-1:0] accum_q, accum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  state_t           state;
  logic             accept;
  logic             complete;
  logic [OUT_W-1:0] word;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q   <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      pending_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      accum_q   <= accum_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_comb begin
    state     = ST_EMPTY;
    accum_d   = accum_q;
    idx_d     = idx_q;
    out_d     = out_q;
    pending_d = pending_q;
    wr_cnt_d  = wr_cnt_q;
    word      = '0;

    if (pending_q)
      state = ST_HOLD;
    else if (idx_q != '0)
      state = ST_FILL;

    din_ready = !((state == ST_HOLD) && fifo_wfull);
    fifo_winc = (state == ST_HOLD) && !fifo_wfull;
    busy      = (state != ST_EMPTY);
    accept    = din_valid && din_ready;
    complete  = accept && ((idx_q == IDX_W'(RATIO - 1)) || din_last);

    // Held slots below idx, current chunk at idx, padding above.
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(idx_q))
        word[i*IN_W +: IN_W] = accum_q[i*IN_W +: IN_W];
      else if (i == int'(idx_q))
        word[i*IN_W +: IN_W] = din;
      else
        word[i*IN_W +: IN_W] = PAD;
    end

    if (fifo_winc) begin
      pending_d = 1'b0;
      if (wr_cnt_q != '1)
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    // Completion overrides the drain so a back-to-back word keeps pending high.
    if (complete) begin
      out_d     = word;
      pending_d = 1'b1;
      idx_d     = '0;
      accum_d   = '0;
    end else if (accept) begin
      accum_d[int'(idx_q)*IN_W +: IN_W] = din;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  assign fifo_wdata = out_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: two instances (PAD=0/CNT_W=16 and PAD=2'b10/CNT_W=2)
// share stimulus and are compared cycle by cycle against a queue-based model.
module tb_fifo_wr_packer;

  logic       wclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0;
  logic [1:0] din = '0;
  logic       din_last = 1'b0;
  logic       fifo_wfull = 1'b0;

  logic        ready0, winc0, busy0;
  logic [7:0]  wdata0;
  logic [15:0] cnt0;
  logic        ready1, winc1, busy1;
  logic [7:0]  wdata1;
  logic [1:0]  cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [1:0] part[$];
  logic       m_pend = 1'b0;
  logic [7:0] m_out0 = '0;
  logic [7:0] m_out1 = '0;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  always #5 wclk = ~wclk;

  fifo_wr_packer #(.IN_W(2), .OUT_W(8), .PAD(2'b00), .CNT_W(16)) dut0 (
    .wclk(wclk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_last(din_last),
    .din_ready(ready0), .fifo_wfull(fifo_wfull), .fifo_winc(winc0),
    .fifo_wdata(wdata0), .wr_cnt(cnt0), .busy(busy0));

  fifo_wr_packer #(.IN_W(2), .OUT_W(8), .PAD(2'b10), .CNT_W(2)) dut1 (
    .wclk(wclk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .din_last(din_last),
    .din_ready(ready1), .fifo_wfull(fifo_wfull), .fifo_winc(winc1),
    .fifo_wdata(wdata1), .wr_cnt(cnt1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] build(input logic [1:0] pad);
    logic [7:0] w = '0;
    for (int i = 0; i < 4; i++)
      w[i*2 +: 2] = (i < part.size()) ? part[i] : pad;
    return w;
  endfunction

  task automatic model_reset();
    part.delete();
    m_pend = 1'b0;
    m_out0 = '0;
    m_out1 = '0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  task automatic check_outputs(input logic f);
    logic e_ready, e_winc, e_busy;
    e_ready = !(m_pend && f);
    e_winc  = m_pend && !f;
    e_busy  = m_pend || (part.size() != 0);
    chk("ready0", 32'(ready0), 32'(e_ready));
    chk("ready1", 32'(ready1), 32'(e_ready));
    chk("winc0", 32'(winc0), 32'(e_winc));
    chk("winc1", 32'(winc1), 32'(e_winc));
    chk("wdata0", 32'(wdata0), 32'(m_out0));
    chk("wdata1", 32'(wdata1), 32'(m_out1));
    chk("busy0", 32'(busy0), 32'(e_busy));
    chk("busy1", 32'(busy1), 32'(e_busy));
    chk("cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));
  endtask

  task automatic step(input logic v, input logic [1:0] d, input logic l, input logic f);
    logic e_ready, e_winc;
    @(negedge wclk);
    din_valid = v; din = d; din_last = l; fifo_wfull = f;
    #1;
    check_outputs(f);
    e_ready = !(m_pend && f);
    e_winc  = m_pend && !f;
    if (e_winc) begin
      m_pend = 1'b0;
      if (m_cnt0 < 65535) m_cnt0++;
      if (m_cnt1 < 3) m_cnt1++;
    end
    if (v && e_ready) begin
      part.push_back(d);
      if (part.size() == 4 || l) begin
        m_out0 = build(2'b00);
        m_out1 = build(2'b10);
        m_pend = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge wclk);
    rst_n = 1'b0;
    din_valid = 1'b0;
    fifo_wfull = 1'b0;
    #1;
    model_reset();
    chk("rst_winc0", 32'(winc0), 32'd0);
    chk("rst_winc1", 32'(winc1), 32'd0);
    check_outputs(1'b0);
    @(negedge wclk);
    rst_n = 1'b1;
  endtask

  int exp_sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    #2;
    check_outputs(1'b0);
    chk("rst_wdata", 32'(wdata0), 32'h0);
    @(negedge wclk);
    rst_n = 1'b1;

    // basic full word
    step(1, 2'b01, 0, 0); step(1, 2'b10, 0, 0); step(1, 2'b11, 0, 0); step(1, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    chk("t1_winc", 32'(winc0), 32'd1);
    chk("t1_word", 32'(wdata0), 32'h39);
    step(0, 2'b00, 0, 0);
    chk("t1_winc_once", 32'(winc0), 32'd0);
    chk("t1_cnt", 32'(cnt0), 32'd1);

    // flushed partial word with both pad values
    step(1, 2'b11, 0, 0); step(1, 2'b01, 1, 0);
    step(0, 2'b00, 0, 0);
    chk("t2_pad0", 32'(wdata0), 32'h07);
    chk("t2_pad2", 32'(wdata1), 32'hA7);
    step(0, 2'b00, 0, 0);
    chk("t2_busy", 32'(busy0), 32'd0);

    // back-pressure hold for 5 cycles
    step(1, 2'b01, 0, 0); step(1, 2'b10, 0, 0); step(1, 2'b11, 0, 0); step(1, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'(i), 0, 1);
      chk("t3_hold", 32'(wdata0), 32'h39);
    end
    step(0, 2'b00, 0, 0);
    chk("t3_release", 32'(winc0), 32'd1);

    // 16 chunks back-to-back
    for (int i = 0; i < 16; i++) step(1, 2'($urandom_range(0, 3)), 0, 0);
    step(0, 2'b00, 0, 0); step(0, 2'b00, 0, 0);

    // reset while partial and pending
    step(1, 2'b01, 0, 0); step(1, 2'b10, 0, 0); step(1, 2'b11, 0, 0); step(1, 2'b00, 0, 0);
    step(1, 2'b11, 0, 1); step(1, 2'b10, 0, 1); step(0, 2'b00, 0, 1);
    pulse_reset();
    step(1, 2'b00, 0, 0); step(1, 2'b01, 0, 0); step(1, 2'b10, 0, 0); step(1, 2'b11, 0, 0);
    step(0, 2'b00, 0, 0);
    chk("t5_word", 32'(wdata0), 32'hE4);

    // saturation of the 2-bit counter
    pulse_reset();
    for (int w = 0; w < 5; w++) begin
      step(1, 2'($urandom_range(0, 3)), 1, 0);
      step(0, 2'b00, 0, 0);
      step(0, 2'b00, 0, 0);
      chk("t6_sat", 32'(cnt1), 32'(exp_sat[w]));
    end

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 3));
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
